// File: rtl/alu_4bit.sv
// Registered 4-bit ALU: arithmetic, logic and shift operations on unsigned
// operands A/B selected by OP, with an 8-bit result captured every clock.
module alu_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] OP,
    output logic [7:0] R
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0111;
    localparam logic [3:0] OP_MOD  = 4'b1111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;

    // Restoring division, returns {remainder, quotient}; divisor must be non-zero.
    function automatic logic [7:0] divmod(input logic [3:0] num, input logic [3:0] den);
        logic [4:0] rem;
        logic [3:0] quo;
        rem = 5'd0;
        quo = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            rem = {rem[3:0], num[i]};
            if (rem >= {1'b0, den}) begin
                rem    = rem - {1'b0, den};
                quo[i] = 1'b1;
            end
        end
        return {rem[3:0], quo};
    endfunction

    logic [7:0] a_ext;
    logic [7:0] b_ext;
    logic [7:0] dm;
    logic [7:0] r_d;
    logic [7:0] r_q;

    assign a_ext = {4'h0, A};
    assign b_ext = {4'h0, B};
    assign dm    = divmod(A, B);

    always_comb begin
        r_d = 8'h00;
        case (OP)
            OP_ADD:  r_d = a_ext + b_ext;
            OP_SUB:  r_d = a_ext - b_ext;
            OP_MUL:  r_d = a_ext * b_ext;
            OP_DIV:  r_d = (B == 4'h0) ? 8'hFF : {4'h0, dm[3:0]};
            OP_MOD:  r_d = (B == 4'h0) ? a_ext : {4'h0, dm[7:4]};
            OP_AND:  r_d = {4'h0, A & B};
            OP_OR:   r_d = {4'h0, A | B};
            OP_XOR:  r_d = {4'h0, A ^ B};
            OP_NAND: r_d = {4'h0, ~(A & B)};
            OP_SHL:  r_d = a_ext << B[2:0];
            OP_SHR:  r_d = a_ext >> B[2:0];
            default: r_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 8'h00;
        end else begin
            r_q <= r_d;
        end
    end

    assign R = r_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Scoreboard bench for alu_4bit: stimulus pushes expected results, a monitor
// pops and compares one cycle later; reset behaviour is checked directly.
module tb_alu_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] OP;
    logic [7:0] R;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_vec;
    int   n_mis;
    bit   stim_done;

    alu_4bit dut (
        .clk(clk),
        .rst(rst),
        .A  (A),
        .B  (B),
        .OP (OP),
        .R  (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        int ai;
        int bi;
        int res;
        ai  = int'(a);
        bi  = int'(b);
        res = 0;
        case (op)
            4'b0000: res = ai + bi;
            4'b0001: res = ai - bi + 256;
            4'b0011: res = ai * bi;
            4'b0111: res = (bi == 0) ? 255 : ai / bi;
            4'b1111: res = (bi == 0) ? ai : ai % bi;
            4'b1000: res = ai & bi;
            4'b1001: res = ai | bi;
            4'b1011: res = ai ^ bi;
            4'b1010: res = (~(ai & bi)) & 15;
            4'b1100: res = ai * (1 << (bi % 8));
            4'b1101: res = ai / (1 << (bi % 8));
            default: res = 0;
        endcase
        return res[7:0];
    endfunction

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                         input logic [7:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        A  = a;
        B  = b;
        OP = op;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic check_now(input logic [7:0] exp, input string name);
        n_vec++;
        if (R !== exp) begin
            n_mis++;
            $display("FAIL %s: R=%02h expected %02h", name, R, exp);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic stimulus();
        logic [3:0] ops[11];
        logic [7:0] exps[11];
        logic [3:0] undef[5];
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rop;

        ops  = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1000,
                 4'b1001, 4'b1011, 4'b1010, 4'b1100, 4'b1101};
        exps = '{8'h0C, 8'h02, 8'h23, 8'h01, 8'h02, 8'h05,
                 8'h07, 8'h02, 8'h0A, 8'hE0, 8'h00};
        undef = '{4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b1110};

        rst = 1'b1;
        A   = 4'h0;
        B   = 4'h0;
        OP  = 4'h0;
        #1;
        check_now(8'h00, "reset_initial");
        @(negedge clk);
        @(negedge clk);
        check_now(8'h00, "reset_held");
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            apply(4'h7, 4'h5, ops[i], exps[i], $sformatf("op_sweep_%b", ops[i]));

        apply(4'h5, 4'h7, 4'b0001, 8'hFE, "sub_wrap");
        apply(4'hF, 4'hF, 4'b0011, 8'hE1, "mul_max");
        apply(4'hF, 4'h3, 4'b1100, 8'h78, "shl_3");
        apply(4'hF, 4'h7, 4'b1100, 8'h80, "shl_7");
        apply(4'hF, 4'h8, 4'b1101, 8'h0F, "shr_b3_ignored");
        apply(4'hF, 4'h8, 4'b1100, 8'h0F, "shl_b3_ignored");
        apply(4'h9, 4'h0, 4'b0111, 8'hFF, "div_by_zero");
        apply(4'h9, 4'h0, 4'b1111, 8'h09, "mod_by_zero");
        apply(4'hF, 4'h0, 4'b1101, 8'h0F, "shr_0_pass");
        apply(4'hE, 4'h3, 4'b0111, 8'h04, "div_14_3");
        apply(4'hE, 4'h3, 4'b1111, 8'h02, "mod_14_3");
        for (int i = 0; i < 5; i++)
            apply(4'hF, 4'hF, undef[i], 8'h00, $sformatf("undef_%b", undef[i]));

        // Async reset asserted mid-cycle must clear R before the next edge.
        apply(4'hF, 4'hF, 4'b0011, 8'hE1, "pre_reset_load");
        drain();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_now(8'h00, "reset_async_mid_cycle");
        @(negedge clk);
        rst = 1'b0;
        apply(4'hF, 4'hF, 4'b0000, 8'h1E, "first_after_reset");

        for (int i = 0; i < 1000; i++) begin
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rop = 4'($urandom_range(0, 15));
            apply(ra, rb, rop, ref_alu(ra, rb, rop), $sformatf("rand_%0d", i));
        end
        drain();
        stim_done = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        int   cycles;
        cycles = 0;
        while (!stim_done) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles > 5000) begin
                n_vec++;
                n_mis++;
                $display("FAIL timeout: %0d cycles, expected under 5000", cycles);
                stim_done = 1'b1;
            end else if (q.size() != 0 && !rst) begin
                e = q.pop_front();
                n_vec++;
                if (R !== e.exp) begin
                    n_mis++;
                    $display("FAIL %s: R=%02h expected %02h", e.name, R, e.exp);
                end
            end
        end
    endtask

    initial begin
        n_vec     = 0;
        n_mis     = 0;
        stim_done = 1'b0;
        fork
            stimulus();
            monitor();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
